vending_machine_multi: RTL and testbench
========================================

VENDING_MACHINE_MULTI -- requirements
Module: vending_machine_multi

Interface
REQ-001 SHALL have parameter PRICE, default 5, item price in half-yuan units; legal range 1..(2^CW - 4).
REQ-002 SHALL have parameter CW, default 4, width of the credit and change registers; 2^CW SHALL exceed PRICE+3.
REQ-003 SHALL have port sys_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pHalf  input  1  0.5-yuan coin accepted this cycle (1 unit).
REQ-006 SHALL have port pOne  input  1  1-yuan coin accepted this cycle (2 units).
REQ-007 SHALL have port pTwo  input  1  2-yuan coin accepted this cycle (4 units).
REQ-008 SHALL have port cancel  input  1  refund request.
REQ-009 SHALL have port PCola  output  1  one-cycle dispense pulse.
REQ-010 SHALL have port PMoney  output  1  change/refund pulse, one 0.5-yuan unit per high cycle.
REQ-011 SHALL have port coin_reject  output  1  one-cycle pulse: the coin in the previous cycle was not credited.
REQ-012 SHALL have port busy  output  1  high in VEND, CHANGE, REFUND.
REQ-013 SHALL have port credit  output  CW  current accumulated credit in units.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, VEND, CHANGE, REFUND; all outputs registered or decoded from state only.
REQ-015 In IDLE, exactly one coin input high at an edge SHALL add its value to credit at that edge.
REQ-016 In IDLE, if the updated credit is >= PRICE, the state SHALL go to VEND at the same edge; change register = credit+value-PRICE.
REQ-017 PCola SHALL be 1 for exactly the single cycle spent in VEND; latency from the coin edge to PCola high SHALL be one cycle.
REQ-018 From VEND, the state SHALL go to CHANGE if change>0, else to IDLE; credit SHALL clear to 0 on leaving VEND.
REQ-019 In CHANGE and REFUND, PMoney SHALL be 1 every cycle, and the count SHALL decrement by 1 per edge.
REQ-020 When the count is 1 at an edge in CHANGE or REFUND, the state SHALL return to IDLE, leaving count 0; total PMoney pulses SHALL equal the initial count exactly.
REQ-021 cancel in IDLE with credit>0 SHALL load the count with credit, clear credit, and enter REFUND; with credit=0 it SHALL do nothing.
REQ-022 cancel SHALL take priority over any same-cycle coin; that coin SHALL be uncredited, with coin_reject=1 in the next cycle.
REQ-023 Two or more coin inputs high in one cycle SHALL credit nothing, with coin_reject=1 in the next cycle.
REQ-024 Any coin while busy=1 SHALL be uncredited, with coin_reject=1 in the next cycle; cancel while busy SHALL be ignored.
REQ-025 Credit arithmetic SHALL never wrap: the REQ-002 bound guarantees credit+4 fits in CW bits.
REQ-026 PCola and PMoney SHALL never be high in the same cycle.

Reset
REQ-027 sys_rst=1 at an edge SHALL force IDLE, credit=0, count=0, PCola=0, PMoney=0, coin_reject=0, busy=0, regardless of state.
REQ-028 Reset asserted mid-CHANGE or mid-REFUND SHALL abandon the remaining pulses; no PMoney after reset.
REQ-029 Inputs SHALL be ignored during any cycle with sys_rst=1.

Verification (PRICE=5, CW=4 unless stated)
REQ-030 Five pHalf pulses on consecutive cycles -> credit 1,2,3,4; PCola high one cycle after the fifth; zero PMoney; credit 0 after.
REQ-031 pOne,pOne,pTwo -> credit 2,4, then 8 -> VEND; PCola 1 cycle; then PMoney exactly 3 consecutive cycles; back to IDLE, busy=0.
REQ-032 pOne, then cancel -> REFUND; PMoney exactly 2 cycles; credit 0; no PCola.
REQ-033 pHalf and pOne high in the same cycle -> credit unchanged, coin_reject 1 cycle; pOne during CHANGE -> coin_reject, change count unaffected.
REQ-034 sys_rst=1 during the 2nd PMoney cycle of a 3-unit change -> all outputs 0 the next cycle, state IDLE, no further PMoney.
REQ-035 PRICE=3, CW=3: pTwo -> PCola, then 1 PMoney; random single-coin stimulus over 10^4 cycles -> total PCola*PRICE + total PMoney = total credited units.

Source files
------------

// File: rtl/vending_machine_multi.sv
// Multi-coin vending machine: credits 0.5/1/2-yuan coins, dispenses at PRICE,
// then pays change or a cancel refund one half-yuan unit per cycle.
module vending_machine_multi #(
  parameter int PRICE = 5,
  parameter int CW    = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          pHalf,
  input  logic          pOne,
  input  logic          pTwo,
  input  logic          cancel,
  output logic          PCola,
  output logic          PMoney,
  output logic          coin_reject,
  output logic          busy,
  output logic [CW-1:0] credit
);

  localparam logic [CW-1:0] LP_PRICE = CW'(PRICE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VEND,
    S_CHANGE,
    S_REFUND
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_credit;
  logic [CW-1:0] w_credit_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_reject;
  logic          w_reject_nxt;

  logic          w_any_coin;
  logic          w_multi_coin;
  logic [CW-1:0] w_coin_val;
  logic [CW-1:0] w_sum;

  assign w_any_coin   = pHalf | pOne | pTwo;
  assign w_multi_coin = (pHalf & pOne) | (pHalf & pTwo) | (pOne & pTwo);
  assign w_coin_val   = pTwo ? CW'(4) : (pOne ? CW'(2) : CW'(1));
  // Credit in IDLE stays below PRICE, so PRICE+3 < 2^CW keeps this sum unwrapped.
  assign w_sum        = r_credit + w_coin_val;

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_count_nxt  = r_count;
    w_reject_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cancel) begin
          w_reject_nxt = w_any_coin;
          if (r_credit != '0) begin
            w_count_nxt  = r_credit;
            w_credit_nxt = '0;
            w_state_nxt  = S_REFUND;
          end
        end else if (w_multi_coin) begin
          w_reject_nxt = 1'b1;
        end else if (w_any_coin) begin
          w_credit_nxt = w_sum;
          if (w_sum >= LP_PRICE) begin
            w_count_nxt = w_sum - LP_PRICE;
            w_state_nxt = S_VEND;
          end
        end
      end
      S_VEND: begin
        w_reject_nxt = w_any_coin;
        w_credit_nxt = '0;
        w_state_nxt  = (r_count != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE, S_REFUND: begin
        w_reject_nxt = w_any_coin;
        if (r_count <= CW'(1)) begin
          w_count_nxt = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_count_nxt = r_count - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_count  <= '0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_count  <= w_count_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  assign PCola       = (r_state == S_VEND);
  assign PMoney      = (r_state == S_CHANGE) || (r_state == S_REFUND);
  assign busy        = (r_state != S_IDLE);
  assign coin_reject = r_reject;
  assign credit      = r_credit;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: two instances (PRICE=5/CW=4 and PRICE=3/CW=3)
// checked cycle by cycle against a pending-work reference model.
module tb_vending_machine_multi;

  logic       clk;
  logic       a_rst, a_half, a_one, a_two, a_cancel;
  logic       a_pcola, a_pmoney, a_reject, a_busy;
  logic [3:0] a_credit;
  logic       b_rst, b_half, b_one, b_two, b_cancel;
  logic       b_pcola, b_pmoney, b_reject, b_busy;
  logic [2:0] b_credit;

  int n_tests = 0;
  int n_fail  = 0;

  vending_machine_multi #(.PRICE(5), .CW(4)) u_dut_a (
    .sys_clk(clk), .sys_rst(a_rst), .pHalf(a_half), .pOne(a_one), .pTwo(a_two),
    .cancel(a_cancel), .PCola(a_pcola), .PMoney(a_pmoney), .coin_reject(a_reject),
    .busy(a_busy), .credit(a_credit)
  );

  vending_machine_multi #(.PRICE(3), .CW(3)) u_dut_b (
    .sys_clk(clk), .sys_rst(b_rst), .pHalf(b_half), .pOne(b_one), .pTwo(b_two),
    .cancel(b_cancel), .PCola(b_pcola), .PMoney(b_pmoney), .coin_reject(b_reject),
    .busy(b_busy), .credit(b_credit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: credit held while idle, plus outstanding work (one cola, N money units).
  typedef struct {
    int credit;
    bit cola;
    int money;
    int vend_credit;
    bit reject;
    int added;
  } model_t;

  model_t m_a, m_b;
  int a_money_tot = 0, a_cola_tot = 0;
  int b_money_tot = 0, b_cola_tot = 0, b_added_tot = 0;

  function automatic model_t model_step(model_t m, int price, bit rst,
                                        bit h, bit o, bit t, bit c);
    model_t n;
    int nc;
    int v;
    n = m;
    nc = int'(h) + int'(o) + int'(t);
    v = int'(h) + 2 * int'(o) + 4 * int'(t);
    n.added = 0;
    n.reject = 1'b0;
    if (rst) begin
      n.credit = 0; n.cola = 1'b0; n.money = 0; n.vend_credit = 0;
      return n;
    end
    if (m.cola || m.money > 0) begin
      if (m.cola) n.cola = 1'b0;
      else n.money = m.money - 1;
      n.reject = (nc > 0);
    end else if (c) begin
      n.reject = (nc > 0);
      if (m.credit > 0) begin
        n.money = m.credit;
        n.credit = 0;
      end
    end else if (nc > 1) begin
      n.reject = 1'b1;
    end else if (nc == 1) begin
      n.added = v;
      if (m.credit + v >= price) begin
        n.cola = 1'b1;
        n.vend_credit = m.credit + v;
        n.money = m.credit + v - price;
        n.credit = 0;
      end else begin
        n.credit = m.credit + v;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("a_pcola",  int'(a_pcola),  int'(m_a.cola));
    check("a_pmoney", int'(a_pmoney), int'(!m_a.cola && m_a.money > 0));
    check("a_busy",   int'(a_busy),   int'(m_a.cola || m_a.money > 0));
    check("a_reject", int'(a_reject), int'(m_a.reject));
    check("a_credit", int'(a_credit), m_a.cola ? m_a.vend_credit : m_a.credit);
    check("b_pcola",  int'(b_pcola),  int'(m_b.cola));
    check("b_pmoney", int'(b_pmoney), int'(!m_b.cola && m_b.money > 0));
    check("b_busy",   int'(b_busy),   int'(m_b.cola || m_b.money > 0));
    check("b_reject", int'(b_reject), int'(m_b.reject));
    check("b_credit", int'(b_credit), m_b.cola ? m_b.vend_credit : m_b.credit);
    check("no_overlap", int'(a_pcola & a_pmoney) + int'(b_pcola & b_pmoney), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    m_a = model_step(m_a, 5, a_rst, a_half, a_one, a_two, a_cancel);
    m_b = model_step(m_b, 3, b_rst, b_half, b_one, b_two, b_cancel);
    b_added_tot += m_b.added;
    @(negedge clk);
    a_money_tot += int'(a_pmoney);
    a_cola_tot  += int'(a_pcola);
    b_money_tot += int'(b_pmoney);
    b_cola_tot  += int'(b_pcola);
    compare_all();
  endtask

  task automatic drive_a(input bit r, input bit h, input bit o, input bit t, input bit c);
    a_rst = r; a_half = h; a_one = o; a_two = t; a_cancel = c;
    tick();
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) drive_a(0, 0, 0, 0, 0);
  endtask

  int snap_money, snap_cola;

  initial begin
    m_a = '{credit: 0, cola: 1'b0, money: 0, vend_credit: 0, reject: 1'b0, added: 0};
    m_b = m_a;
    a_rst = 1'b1; a_half = 1'b0; a_one = 1'b0; a_two = 1'b0; a_cancel = 1'b0;
    b_rst = 1'b1; b_half = 1'b0; b_one = 1'b0; b_two = 1'b0; b_cancel = 1'b0;
    // Inputs during reset must be ignored.
    tick();
    a_half = 1'b1; a_cancel = 1'b1; b_two = 1'b1;
    tick();
    check("rst_credit", int'(a_credit), 0);
    check("rst_busy", int'(a_busy), 0);
    b_rst = 1'b0; b_two = 1'b0;

    // Five half-yuan coins
    drive_a(0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      drive_a(0, 1, 0, 0, 0);
      check("half_credit", int'(a_credit), i);
    end
    snap_money = a_money_tot;
    drive_a(0, 1, 0, 0, 0);
    check("half_cola", int'(a_pcola), 1);
    idle_a(3);
    check("half_no_change", a_money_tot - snap_money, 0);
    check("half_credit_clr", int'(a_credit), 0);

    // 1 + 1 + 2 yuan -> 3 units change
    drive_a(0, 0, 1, 0, 0);
    check("one_credit", int'(a_credit), 2);
    drive_a(0, 0, 1, 0, 0);
    check("two_credit", int'(a_credit), 4);
    snap_money = a_money_tot;
    drive_a(0, 0, 0, 1, 0);
    check("change_cola", int'(a_pcola), 1);
    idle_a(5);
    check("change_units", a_money_tot - snap_money, 3);
    check("change_busy", int'(a_busy), 0);

    // 1 yuan then cancel -> 2 units refund
    drive_a(0, 0, 1, 0, 0);
    snap_money = a_money_tot; snap_cola = a_cola_tot;
    drive_a(0, 0, 0, 0, 1);
    check("refund_busy", int'(a_busy), 1);
    idle_a(4);
    check("refund_units", a_money_tot - snap_money, 2);
    check("refund_no_cola", a_cola_tot - snap_cola, 0);
    check("refund_credit", int'(a_credit), 0);

    // Cancel with zero credit does nothing
    drive_a(0, 0, 0, 0, 1);
    check("cancel_empty", int'(a_busy), 0);

    // Two coins in one cycle, then a coin while paying change
    drive_a(0, 1, 1, 0, 0);
    check("multi_reject", int'(a_reject), 1);
    check("multi_credit", int'(a_credit), 0);
    drive_a(0, 0, 0, 0, 0);
    check("reject_pulse", int'(a_reject), 0);
    drive_a(0, 0, 1, 0, 0);
    drive_a(0, 0, 1, 0, 0);
    snap_money = a_money_tot;
    drive_a(0, 0, 0, 1, 0);
    drive_a(0, 0, 0, 0, 0);
    drive_a(0, 0, 1, 0, 0);
    check("busy_reject", int'(a_reject), 1);
    idle_a(4);
    check("busy_coin_change", a_money_tot - snap_money, 3);

    // Cancel beats a same-cycle coin
    drive_a(0, 1, 0, 0, 0);
    drive_a(0, 0, 1, 0, 1);
    check("cancel_coin_reject", int'(a_reject), 1);
    idle_a(3);

    // Reset during the second change pulse
    drive_a(0, 0, 1, 0, 0);
    drive_a(0, 0, 1, 0, 0);
    drive_a(0, 0, 0, 1, 0);
    drive_a(0, 0, 0, 0, 0);
    drive_a(0, 0, 0, 0, 0);
    check("mid_change_pmoney", int'(a_pmoney), 1);
    drive_a(1, 0, 0, 0, 0);
    check("rst_pmoney", int'(a_pmoney), 0);
    check("rst_busy2", int'(a_busy), 0);
    snap_money = a_money_tot;
    idle_a(4);
    check("rst_no_more_money", a_money_tot - snap_money, 0);

    // PRICE=3: 2-yuan coin -> cola then one unit change
    snap_money = b_money_tot; snap_cola = b_cola_tot;
    b_two = 1'b1;
    tick();
    b_two = 1'b0;
    check("b_two_cola", int'(b_pcola), 1);
    tick(); tick(); tick();
    check("b_two_change", b_money_tot - snap_money, 1);
    check("b_two_cola_cnt", b_cola_tot - snap_cola, 1);

    // Random traffic on both instances
    b_money_tot = 0; b_cola_tot = 0; b_added_tot = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      int r;
      a_rst    = ($urandom_range(0, 299) == 0);
      a_half   = ($urandom_range(0, 3) == 0);
      a_one    = ($urandom_range(0, 3) == 0);
      a_two    = ($urandom_range(0, 3) == 0);
      a_cancel = ($urandom_range(0, 11) == 0);
      r = $urandom_range(0, 9);
      b_half   = (r == 0);
      b_one    = (r == 1);
      b_two    = (r == 2);
      b_cancel = ($urandom_range(0, 29) == 0);
      tick();
    end
    a_rst = 1'b0; a_half = 1'b0; a_one = 1'b0; a_two = 1'b0; a_cancel = 1'b0;
    b_half = 1'b0; b_one = 1'b0; b_two = 1'b0; b_cancel = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    // Drain any leftover credit before balancing the books.
    b_cancel = 1'b1;
    tick();
    b_cancel = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("b_conservation", b_cola_tot * 3 + b_money_tot, b_added_tot);
    check("b_final_idle", int'(b_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
